// File: rtl/qpu_dtcm_icb_master_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : qpu_dtcm_icb_master_pkg
//  Purpose  : Shared constants for the DTCM ICB block-transfer initiator:
//             FSM state encoding, full-word write mask and word address step.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package qpu_dtcm_icb_master_pkg;

    // FSM state encoding
    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_CMD   = 3'd1;
    localparam logic [2:0] c_ST_RSP   = 3'd2;
    localparam logic [2:0] c_ST_RDOUT = 3'd3;
    localparam logic [2:0] c_ST_FIN   = 3'd4;

    // All four byte lanes enabled for a full-word write
    localparam logic [3:0] c_WMASK_FULL = 4'hF;

    // Byte distance between consecutive words
    localparam int unsigned c_ADDR_STEP = 4;

endpackage : qpu_dtcm_icb_master_pkg
`default_nettype wire

// File: rtl/qpu_dtcm_icb_master.sv
`default_nettype none
// ============================================================================
//  Module   : qpu_dtcm_icb_master
//  Purpose  : ICB initiator that copies word blocks into / out of the DTCM,
//             one single-beat transaction at a time (single outstanding).
//  Ports    : clk/rst           - clock, synchronous active-high reset
//             req_*             - block request (read flag, start addr, length)
//             wr_*              - write-data stream (valid/ready)
//             rd_*              - registered read-data stream (valid/ready)
//             busy/done         - block in progress / one-cycle completion pulse
//             icb_cmd_*/icb_rsp_* - ICB command and response channels
//  Revision : 1.0 - initial release
// ============================================================================
module qpu_dtcm_icb_master
    import qpu_dtcm_icb_master_pkg::*;
#(
    parameter int AW    = 16,
    parameter int DW    = 32,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_read,
    input  logic [AW-1:0]    req_addr,
    input  logic [LEN_W-1:0] req_len,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [DW-1:0]    wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [DW-1:0]    rd_data,
    output logic             busy,
    output logic             done,
    output logic             icb_cmd_valid,
    input  logic             icb_cmd_ready,
    output logic [AW-1:0]    icb_cmd_addr,
    output logic             icb_cmd_read,
    output logic [DW-1:0]    icb_cmd_wdata,
    output logic [3:0]       icb_cmd_wmask,
    input  logic             icb_rsp_valid,
    output logic             icb_rsp_ready,
    input  logic [DW-1:0]    icb_rsp_rdata
);

    logic [2:0]       r_state;
    logic [AW-1:0]    r_addr;
    logic [LEN_W-1:0] r_cnt;
    logic             r_read;
    logic [DW-1:0]    r_rd_data;

    logic w_in_cmd;
    logic w_in_rsp;
    logic w_in_rdout;
    logic w_cmd_hs;
    logic w_advance;
    logic w_last;
    logic w_unused_addr_bits;

    assign w_in_cmd   = (r_state == c_ST_CMD);
    assign w_in_rsp   = (r_state == c_ST_RSP);
    assign w_in_rdout = (r_state == c_ST_RDOUT);
    assign w_cmd_hs   = icb_cmd_valid & icb_cmd_ready;
    assign w_last     = (r_cnt == LEN_W'(1));

    // One word finished: write response accepted, or read word drained
    assign w_advance = (w_in_rsp & icb_rsp_valid & ~r_read)
                     | (w_in_rdout & rd_ready);

    // Start address is word aligned; the byte offset is discarded
    assign w_unused_addr_bits = ^req_addr[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_addr    <= '0;
            r_cnt     <= '0;
            r_read    <= 1'b0;
            r_rd_data <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (req_valid) begin
                        r_addr  <= {req_addr[AW-1:2], 2'b00};
                        r_read  <= req_read;
                        r_cnt   <= req_len;
                        r_state <= (req_len == '0) ? c_ST_FIN : c_ST_CMD;
                    end
                end
                c_ST_CMD: begin
                    if (w_cmd_hs) begin
                        r_state <= c_ST_RSP;
                    end
                end
                c_ST_RSP: begin
                    if (icb_rsp_valid) begin
                        if (r_read) begin
                            r_rd_data <= icb_rsp_rdata;
                            r_state   <= c_ST_RDOUT;
                        end else begin
                            r_state <= w_last ? c_ST_FIN : c_ST_CMD;
                        end
                    end
                end
                c_ST_RDOUT: begin
                    if (rd_ready) begin
                        r_state <= w_last ? c_ST_FIN : c_ST_CMD;
                    end
                end
                c_ST_FIN: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase

            // Address wraps naturally modulo 2^AW
            if (w_advance) begin
                r_addr <= r_addr + AW'(c_ADDR_STEP);
                r_cnt  <= r_cnt - LEN_W'(1);
            end
        end
    end

    assign req_ready     = (r_state == c_ST_IDLE);
    assign busy          = (r_state != c_ST_IDLE);
    assign done          = (r_state == c_ST_FIN);
    assign rd_valid      = w_in_rdout;
    assign rd_data       = r_rd_data;

    // Write commands follow the stream valid; the stream ready mirrors the
    // ICB ready so both handshakes complete in the same cycle.
    assign icb_cmd_valid = w_in_cmd & (r_read | wr_valid);
    assign icb_cmd_addr  = r_addr;
    assign icb_cmd_read  = w_in_cmd & r_read;
    assign icb_cmd_wdata = (w_in_cmd & ~r_read) ? wr_data : '0;
    assign icb_cmd_wmask = (w_in_cmd & ~r_read) ? c_WMASK_FULL : 4'h0;
    assign wr_ready      = w_in_cmd & ~r_read & icb_cmd_ready;
    assign icb_rsp_ready = w_in_rsp;

endmodule : qpu_dtcm_icb_master
`default_nettype wire

// File: tb/tb_qpu_dtcm_icb_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_qpu_dtcm_icb_master
//  Purpose  : Self-checking bench for qpu_dtcm_icb_master with a 1-cycle
//             DTCM responder, expected-transaction queues and a shadow memory.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_qpu_dtcm_icb_master;

    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic             req_read = 1'b0;
    logic [AW-1:0]    req_addr = '0;
    logic [LEN_W-1:0] req_len = '0;
    logic             wr_valid = 1'b0;
    logic             wr_ready;
    logic [DW-1:0]    wr_data = '0;
    logic             rd_valid;
    logic             rd_ready = 1'b0;
    logic [DW-1:0]    rd_data;
    logic             busy;
    logic             done;
    logic             icb_cmd_valid;
    logic             icb_cmd_ready = 1'b0;
    logic [AW-1:0]    icb_cmd_addr;
    logic             icb_cmd_read;
    logic [DW-1:0]    icb_cmd_wdata;
    logic [3:0]       icb_cmd_wmask;
    logic             icb_rsp_valid = 1'b0;
    logic             icb_rsp_ready;
    logic [DW-1:0]    icb_rsp_rdata = '0;

    always #5 clk = ~clk;

    qpu_dtcm_icb_master #(.AW(AW), .DW(DW), .LEN_W(LEN_W)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_read      (req_read),
        .req_addr      (req_addr),
        .req_len       (req_len),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_data       (wr_data),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_data       (rd_data),
        .busy          (busy),
        .done          (done),
        .icb_cmd_valid (icb_cmd_valid),
        .icb_cmd_ready (icb_cmd_ready),
        .icb_cmd_addr  (icb_cmd_addr),
        .icb_cmd_read  (icb_cmd_read),
        .icb_cmd_wdata (icb_cmd_wdata),
        .icb_cmd_wmask (icb_cmd_wmask),
        .icb_rsp_valid (icb_rsp_valid),
        .icb_rsp_ready (icb_rsp_ready),
        .icb_rsp_rdata (icb_rsp_rdata)
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [15:0] addr;
        logic        rd;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } cmd_t;

    cmd_t        exp_cmd[$];
    logic [31:0] exp_rd[$];
    logic [31:0] wq[$];
    logic [31:0] dtcm    [0:16383];
    logic [31:0] ref_mem [0:16383];

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;

    // Traffic knobs (percent probabilities, response delay, forced stall)
    int p_cmd = 100, p_wr = 100, p_rd = 100, max_dly = 0, rd_hold = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit coin(input int p);
        return int'($urandom_range(99, 0)) < p;
    endfunction

    // ------------------------------------------------------------------
    // DTCM responder, stream drivers and protocol monitor
    // Drive just after negedge, sample 1 time unit later.
    // ------------------------------------------------------------------
    bit          pend = 1'b0;
    logic [31:0] pend_data = '0;
    int          pend_dly = 0;
    bit          prv_rd_stall = 1'b0;
    logic [31:0] prv_rd_data = '0;
    bit          prv_cmd_stall = 1'b0;
    logic [15:0] prv_cmd_addr = '0;
    cmd_t        m_e;
    logic [31:0] m_d;

    always @(negedge clk) begin
        icb_cmd_ready = coin(p_cmd);
        if (pend && pend_dly > 0) begin
            pend_dly--;
            icb_rsp_valid = 1'b0;
        end else begin
            icb_rsp_valid = pend;
        end
        icb_rsp_rdata = icb_rsp_valid ? pend_data : $urandom;
        if (wq.size() > 0 && coin(p_wr)) begin
            wr_valid = 1'b1;
            wr_data  = wq[0];
        end else begin
            wr_valid = 1'b0;
            wr_data  = $urandom;
        end
        if (rd_hold > 0 && rd_valid) begin
            rd_ready = 1'b0;
            rd_hold--;
        end else begin
            rd_ready = coin(p_rd);
        end
        #1;
        if (rst) begin
            pend          = 1'b0;
            prv_rd_stall  = 1'b0;
            prv_cmd_stall = 1'b0;
        end else begin
            if (prv_rd_stall) begin
                chk("rd_hold_valid", rd_valid, 1);
                chk("rd_hold_data", rd_data, prv_rd_data);
            end
            if (prv_cmd_stall) begin
                chk("cmd_hold_valid", icb_cmd_valid, 1);
                chk("cmd_hold_addr", icb_cmd_addr, prv_cmd_addr);
            end
            if (icb_cmd_valid)
                chk("cmd_single_outstanding", pend | rd_valid, 0);
            if (icb_cmd_valid && !icb_cmd_read)
                chk("wr_ready_pass", wr_ready, icb_cmd_ready);
            if (icb_rsp_valid && icb_rsp_ready)
                pend = 1'b0;
            if (wr_valid && wr_ready)
                void'(wq.pop_front());
            if (icb_cmd_valid && icb_cmd_ready) begin
                if (exp_cmd.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_cmd: got addr %h rd %b expected none", icb_cmd_addr, icb_cmd_read);
                end else begin
                    m_e = exp_cmd.pop_front();
                    chk("cmd_addr", icb_cmd_addr, m_e.addr);
                    chk("cmd_read", icb_cmd_read, m_e.rd);
                    chk("cmd_wdata", icb_cmd_wdata, m_e.wdata);
                    chk("cmd_wmask", icb_cmd_wmask, m_e.wmask);
                end
                if (icb_cmd_read) pend_data = dtcm[icb_cmd_addr[15:2]];
                else              dtcm[icb_cmd_addr[15:2]] = icb_cmd_wdata;
                pend     = 1'b1;
                pend_dly = int'($urandom_range(max_dly, 0));
            end
            if (rd_valid && rd_ready) begin
                if (exp_rd.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_rd: got %h expected none", rd_data);
                end else begin
                    m_d = exp_rd.pop_front();
                    chk("rd_data", rd_data, m_d);
                end
            end
            if (done) n_done++;
            prv_rd_stall  = rd_valid && !rd_ready;
            prv_rd_data   = rd_data;
            prv_cmd_stall = icb_cmd_valid && !icb_cmd_ready && icb_cmd_read;
            prv_cmd_addr  = icb_cmd_addr;
        end
    end

    // ------------------------------------------------------------------
    // Block model: the expected ICB sequence is base + 4*i modulo 2^16
    // ------------------------------------------------------------------
    task automatic push_block(input bit rd, input logic [15:0] addr, input int len,
                              input logic [31:0] wbase, input bit rnd, input int nexp);
        int   a;
        cmd_t c;
        logic [31:0] d;
        for (int i = 0; i < len; i++) begin
            a = ((int'(addr) / 4) * 4 + 4 * i) % 65536;
            if (rd) begin
                c = '{addr: 16'(a), rd: 1'b1, wdata: 32'h0, wmask: 4'h0};
                if (i < nexp) begin
                    exp_cmd.push_back(c);
                    exp_rd.push_back(ref_mem[a / 4]);
                end
            end else begin
                d = rnd ? $urandom : wbase + 32'(i);
                wq.push_back(d);
                c = '{addr: 16'(a), rd: 1'b0, wdata: d, wmask: 4'hF};
                if (i < nexp) begin
                    exp_cmd.push_back(c);
                    ref_mem[a / 4] = d;
                end
            end
        end
    endtask

    task automatic finish_now();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "bench aborted");
    endtask

    task automatic run_block(input bit rd, input logic [15:0] addr, input int len,
                             input logic [31:0] wbase, input bit rnd, input int exp_cyc);
        int cycles;
        int done0;
        bit got;
        @(negedge clk);
        #2;
        push_block(rd, addr, len, wbase, rnd, len);
        done0 = n_done;
        @(negedge clk);
        req_valid = 1'b1;
        req_read  = rd;
        req_addr  = addr;
        req_len   = LEN_W'(len);
        #2;
        chk("req_ready_idle", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        cycles = 0;
        got = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            #2;
            if (k == 2) req_valid = 1'b0;
            if (busy) begin
                cycles++;
                chk("req_ready_busy", req_ready, 0);
            end
            if (done) begin
                got = 1'b1;
                break;
            end
            // stray request while busy must be ignored
            if (k == 1 && busy) begin
                req_valid = 1'b1;
                req_read  = $urandom;
                req_addr  = $urandom;
                req_len   = $urandom;
            end
            @(negedge clk);
        end
        if (!got) begin
            $display("FAIL block_timeout: got no done expected done within 3000 cycles");
            n_fail++;
            finish_now();
        end
        if (exp_cyc >= 0) chk("busy_cycles", cycles, exp_cyc);
        @(negedge clk);
        #2;
        chk("done_single_pulse", done, 0);
        chk("busy_after_done", busy, 0);
        chk("done_count", n_done - done0, 1);
        chk("cmds_all_issued", exp_cmd.size(), 0);
        chk("rds_all_delivered", exp_rd.size(), 0);
        chk("wr_stream_drained", wq.size(), 0);
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        bit          rd;
        logic [15:0] addr;
        int          len;
        logic [31:0] wbase;
        int          cyc;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int d0;
        for (int i = 0; i < 16384; i++) begin
            dtcm[i]    = 32'hC0DE_0000 | 32'(i);
            ref_mem[i] = 32'hC0DE_0000 | 32'(i);
        end

        // write 2 cycles/word, read 3 cycles/word, plus one FIN cycle
        vecs[0] = '{rd: 0, addr: 16'h0100, len: 4, wbase: 32'hA0, cyc: 9};
        vecs[1] = '{rd: 1, addr: 16'h0100, len: 4, wbase: 32'h0,  cyc: 13};
        vecs[2] = '{rd: 0, addr: 16'h0200, len: 0, wbase: 32'h0,  cyc: 1};
        vecs[3] = '{rd: 1, addr: 16'h0200, len: 0, wbase: 32'h0,  cyc: 1};
        vecs[4] = '{rd: 1, addr: 16'hFFFC, len: 2, wbase: 32'h0,  cyc: 7};
        vecs[5] = '{rd: 1, addr: 16'h0102, len: 1, wbase: 32'h0,  cyc: 4};
        vecs[6] = '{rd: 0, addr: 16'hFFFE, len: 2, wbase: 32'hB0, cyc: 5};
        vecs[7] = '{rd: 1, addr: 16'hFFFC, len: 2, wbase: 32'h0,  cyc: 7};

        // Reset state
        repeat (3) @(negedge clk);
        #2;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_cmd_valid", icb_cmd_valid, 0);
        chk("rst_cmd_addr", icb_cmd_addr, 0);
        chk("rst_cmd_wmask", icb_cmd_wmask, 0);
        chk("rst_rsp_ready", icb_rsp_ready, 0);
        chk("rst_wr_ready", wr_ready, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 8; v++)
            run_block(vecs[v].rd, vecs[v].addr, vecs[v].len, vecs[v].wbase, 1'b0, vecs[v].cyc);

        // Read output backpressure: 5 stalled cycles on word 0
        @(negedge clk);
        #2;
        rd_hold = 5;
        run_block(1'b1, 16'h0100, 2, 32'h0, 1'b0, 12);

        // Reset during the response phase of word 1 of a 3-word write
        @(negedge clk);
        #2;
        push_block(1'b0, 16'h0300, 3, 32'hE0, 1'b0, 2);
        d0 = n_done;
        @(negedge clk);               // N0
        req_valid = 1'b1;
        req_read  = 1'b0;
        req_addr  = 16'h0300;
        req_len   = 8'd3;
        @(negedge clk);               // N1: CMD word 0
        req_valid = 1'b0;
        @(negedge clk);               // N2: RSP word 0
        @(negedge clk);               // N3: CMD word 1
        @(negedge clk);               // N4: RSP word 1
        #2;
        chk("rstmid_in_rsp", icb_rsp_ready, 1);
        rst = 1'b1;
        @(negedge clk);               // N5
        rst = 1'b0;
        #2;
        chk("rstmid_busy", busy, 0);
        chk("rstmid_req_ready", req_ready, 1);
        chk("rstmid_done", done, 0);
        wq.delete();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #2;
            chk("rstmid_no_cmd", icb_cmd_valid, 0);
            chk("rstmid_idle", busy, 0);
        end
        chk("rstmid_no_done_pulse", n_done - d0, 0);
        chk("rstmid_cmds_issued", exp_cmd.size(), 0);

        // Randomized traffic against the shadow-memory model
        for (int r = 0; r < 40; r++) begin
            @(negedge clk);
            #2;
            p_cmd   = int'($urandom_range(100, 30));
            p_wr    = int'($urandom_range(100, 30));
            p_rd    = int'($urandom_range(100, 30));
            max_dly = int'($urandom_range(3, 0));
            run_block($urandom_range(1, 0) == 1, 16'($urandom), int'($urandom_range(6, 0)),
                      32'h0, 1'b1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_qpu_dtcm_icb_master
`default_nettype wire

// File: doc/qpu_dtcm_icb_master.md
Name: qpu_dtcm_icb_master

Overview:
- ICB initiator that moves word blocks into and out of the DTCM through the DTCM controller's LSU-side ICB port.
- Takes a block request (read/write, word-aligned start address, word count). Issues one single-beat ICB transaction at a time, matching the DTCM's single-outstanding rule.
- Write data arrives on a valid/ready stream; read data leaves on a registered valid/ready stream.
- Used by the host-load / readout path to fill or dump DTCM without going through the LSU.

Parameters:
- AW, 16: ICB byte address width; equals QPU_DTCM_ADDR_WIDTH.
- DW, 32: data width; fixed 32, matches DTCM word.
- LEN_W, 8: width of the word-count field.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req_valid  in  1  block request valid
- req_ready  out  1  block request accepted (IDLE only)
- req_read  in  1  1=read DTCM, 0=write DTCM
- req_addr  in  AW  start byte address; bits[1:0] ignored (treated as 0)
- req_len  in  LEN_W  number of words; 0 = no-op
- wr_valid  in  1  write-data stream valid
- wr_ready  out  1  write-data stream ready
- wr_data  in  DW  write word
- rd_valid  out  1  read-data stream valid (registered)
- rd_ready  in  1  read-data stream ready
- rd_data  out  DW  read word (registered)
- busy  out  1  block in progress
- done  out  1  one-cycle pulse at block completion
- icb_cmd_valid  out  1  ICB cmd valid
- icb_cmd_ready  in  1  ICB cmd ready
- icb_cmd_addr  out  AW  ICB cmd address
- icb_cmd_read  out  1  ICB cmd read
- icb_cmd_wdata  out  DW  ICB cmd write data
- icb_cmd_wmask  out  4  ICB cmd byte mask
- icb_rsp_valid  in  1  ICB rsp valid
- icb_rsp_ready  out  1  ICB rsp ready
- icb_rsp_rdata  in  DW  ICB rsp read data

Behaviour:
- Reset (rst high at a clk edge): FSM=IDLE; counters cleared; all outputs 0 except req_ready=1. rd_data=0.
- FSM states: IDLE, CMD, RSP, RDOUT, FIN.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr (low 2 bits forced 0), read flag and len.
  - len==0 -> FIN; else -> CMD.
- CMD:
  - Read: icb_cmd_valid=1, icb_cmd_read=1, icb_cmd_wdata=0.
  - Write: icb_cmd_valid=wr_valid, icb_cmd_wdata=wr_data, wr_ready=icb_cmd_ready (combinational pass-through, so the stream and ICB handshake in the same cycle).
  - icb_cmd_wmask=4'hF for writes, 4'h0 for reads.
  - Cmd handshake -> RSP.
- RSP:
  - Read: icb_rsp_ready=1; on icb_rsp_valid, capture icb_rsp_rdata into rd_data -> RDOUT.
  - Write: icb_rsp_ready=1; on icb_rsp_valid, advance.
  - Advance: addr += 4 (wraps modulo 2^AW), remaining -= 1. Go to FIN if remaining reaches 0, else CMD.
- RDOUT: rd_valid=1 until rd_ready; then advance as above. Backpressure on rd_ready stalls the block indefinitely; no data loss.
- FIN: done=1 for exactly one cycle, then IDLE.
- busy=1 in every state except IDLE.
- At most one ICB transaction outstanding. icb_cmd_valid is never asserted while in RSP or RDOUT.
- Once icb_cmd_valid rises for a read, it holds until the handshake; address is stable.
- Write valid drop: if wr_valid drops before handshake, icb_cmd_valid drops with it.
  - Permitted: the DTCM controller samples only on handshake.
- Latency with a 1-cycle DTCM:
  - Read: 3 cycles/word with rd_ready=1.
  - Write: 2 cycles/word with wr_valid=1.
  - done asserts the cycle after the final advance.
- req_valid outside IDLE is ignored (req_ready=0).
- Reset mid-block returns to IDLE immediately and drops any pending response. The system must reset the DTCM controller in the same cycle.
- ICB response error is not modelled; the DTCM never errors.

Decomposition:
- Shared package: FSM state encoding (3-bit localparams), WMASK_FULL=4'hF, ADDR_STEP=4.
- No sub-module: single FSM with an address/count datapath. The read output register lives inline.

Test Plan:
- Write 4 words from req_addr=0x0100 with wr_data 0xA0..0xA3 and wr_valid held high -> ICB writes to 0x0100,0x0104,0x0108,0x010C with wmask=F, 2 cycles/word, single done pulse after the fourth response.
- Read back the same 4 words with rd_ready=1 -> rd_data=0xA0..0xA3 in order, 3 cycles/word, icb_cmd_wdata=0 and wmask=0 on all reads.
- Read 2 words with rd_ready low for 5 cycles on word 0 -> rd_valid/rd_data held stable, no second ICB cmd issued until the handshake, then completes normally.
- req_len=0 -> busy high for 1 cycle, done pulse, no ICB cmd_valid.
- Read 2 words from req_addr=0xFFFC (AW=16) -> addresses 0xFFFC then 0x0000 (wrap). Also req_addr=0x0102 -> issued address 0x0100.
- Assert rst during RSP of word 1 of a 3-word write -> next cycle IDLE, busy=0, req_ready=1, no done pulse, no further ICB cmds.
